led_driver: RTL and testbench
=============================

LED_DRIVER -- requirements
Module: led_driver

Interface
REQ-001 Parameter TICK_DIV, default 10000000, Clk cycles per pattern step (10 Hz at 100 MHz); legal range >= 2.
REQ-002 Parameter DEB_CYCLES, default 1000000, consecutive stable cycles needed to accept a button level (10 ms at 100 MHz); legal range >= 1.
REQ-003 Clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Switch  input  4  push buttons, active-low (0 = pressed), asynchronous to Clk.
REQ-006 reg_cs  input  1  register select.
REQ-007 reg_wr  input  1  write strobe; a write occurs in a cycle with reg_cs=1 and reg_wr=1.
REQ-008 reg_wdata  input  8  write data.
REQ-009 reg_rdata  output  8  status read data.
REQ-010 LED  output  8  LED drive, 1 = lit, registered.

Function
REQ-011 Each Switch bit SHALL pass a 2-flop synchronizer, then a per-bit debouncer: the debounced level changes only after the synchronized level has differed from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-012 A press event for bit k SHALL be a one-cycle pulse when debounced bit k goes from released to pressed.
REQ-013 Multiple simultaneous press events SHALL select the lowest index.
REQ-014 A press event on button k SHALL, on the next edge, set mode=k (2 bits), clear the manual flag, clear the tick counter and reload the pattern register with the mode's initial value.
REQ-015 The mode SHALL hold after the button is released.
REQ-016 The tick counter SHALL count 0..TICK_DIV-1 and wrap; tick is a one-cycle pulse at count TICK_DIV-1.
REQ-017 Mode 0, binary count: initial 0x00; +1 per tick; 0xFF wraps to 0x00.
REQ-018 Mode 1, rotate: initial 0x01; rotate left by one per tick; 0x80 goes to 0x01.
REQ-019 Mode 2, bounce: initial 0x01 with direction up; shift left per tick until 0x80, then shift right until 0x01, then up again. The sequence is 0x01,0x02,...,0x80,0x40,...,0x01,0x02.
REQ-020 Mode 3, blink: initial 0xFF; invert all bits per tick (0xFF/0x00 alternate).
REQ-021 A register write SHALL load led_reg with reg_wdata and set the manual flag on the same edge.
REQ-022 While the manual flag is 1, LED SHALL equal led_reg one cycle after the write.
REQ-023 While the manual flag is 1, the pattern generator SHALL keep running unobserved.
REQ-024 While the manual flag is 0, LED SHALL equal the pattern register, registered with one cycle of latency.
REQ-025 If a write and a press event occur in the same cycle, the write SHALL win: the manual flag is set, while mode and pattern still update per REQ-014.
REQ-026 reg_rdata SHALL be combinational and equal to {manual, 1'b0, mode[1:0], debounced pressed[3:0]}, pressed = 1; it is independent of reg_cs.
REQ-027 Reads SHALL have no side effects.
REQ-028 Writes with reg_cs=0 SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL asynchronously force LED=0x00, mode=0, manual=0, led_reg=0x00, pattern=0x00, direction=up, tick counter=0, synchronizers and debouncers to released, and press events to 0.
REQ-030 After deassertion, mode-0 counting SHALL start, with the first increment TICK_DIV cycles later.
REQ-031 Reset mid-pattern or mid-debounce SHALL discard all state, with no partial press registered.

Verification (TICK_DIV=4, DEB_CYCLES=3)
REQ-032 Reset release with Switch=4'hF -> LED sequence 0x00,0x01,0x02,... changing every 4 cycles; 0xFF wraps to 0x00.
REQ-033 Switch[2] held low for 6 cycles -> mode=2, LED walks 0x01..0x80..0x01 every 4 cycles; reg_rdata[5:4]=2'b10.
REQ-034 Switch[1] toggling every 2 cycles for 20 cycles -> no mode change (debounce rejects it); a steady press afterwards -> LED rotates 0x01,0x02,...,0x80,0x01.
REQ-035 Write 0xA5 (reg_cs=1, reg_wr=1) -> LED=0xA5 next cycle and held; reg_rdata[7]=1; a Switch[3] press -> manual cleared, LED blinks 0xFF/0x00.
REQ-036 Switch[0] and Switch[3] pressed together -> mode 0 selected, LED restarts at 0x00.
REQ-037 rst_n pulsed low asynchronously mid-mode-2 -> LED=0x00 immediately, mode=0, reg_rdata=0x00.

Source files
------------

// File: rtl/led_driver.sv
// LED pattern driver: debounced push buttons select one of four animated
// patterns; a register write overrides the display with a fixed value.
module led_driver #(
   parameter int TICK_DIV   = 10000000,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic       Clk,
   input  logic       rst_n,
   input  logic [3:0] Switch,
   input  logic       reg_cs,
   input  logic       reg_wr,
   input  logic [7:0] reg_wdata,
   output logic [7:0] reg_rdata,
   output logic [7:0] LED
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      MODE_COUNT  = 2'd0,
      MODE_ROTATE = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_t;

   function automatic logic [7:0] pattern_init(input mode_t m);
      case (m)
         MODE_COUNT:  pattern_init = 8'h00;
         MODE_ROTATE: pattern_init = 8'h01;
         MODE_BOUNCE: pattern_init = 8'h01;
         default:     pattern_init = 8'hFF;
      endcase
   endfunction

   // Button input path; levels kept in switch polarity (1 = released)
   logic [3:0]          sync_a;
   logic [3:0]          sync_b;
   logic [3:0]          deb_lvl;
   logic [3:0]          press;
   logic [3:0][DW-1:0]  deb_cnt;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a  <= 4'hF;
         sync_b  <= 4'hF;
         deb_lvl <= 4'hF;
         press   <= 4'h0;
         deb_cnt <= '0;
      end else begin
         sync_a <= Switch;
         sync_b <= sync_a;
         for (int i = 0; i < 4; i++) begin
            press[i] <= 1'b0;
            if (sync_b[i] == deb_lvl[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb_cnt[i] <= '0;
               deb_lvl[i] <= sync_b[i];
               press[i]   <= ~sync_b[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   logic       press_hit;
   logic [1:0] press_idx;

   // Descending scan so the lowest pressed index is the one kept
   always_comb begin
      press_hit = 1'b0;
      press_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (press[i]) begin
            press_hit = 1'b1;
            press_idx = 2'(i);
         end
      end
   end

   mode_t         mode, mode_next;
   logic [7:0]    pattern, pattern_next;
   logic          dir_up, dir_up_next;
   logic [TW-1:0] tick_cnt, tick_cnt_next;
   logic          manual, manual_next;
   logic [7:0]    led_reg, led_reg_next;
   logic          tick;
   logic          wr_en;

   assign tick  = (tick_cnt == TICK_LAST);
   assign wr_en = reg_cs & reg_wr;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         mode     <= MODE_COUNT;
         pattern  <= 8'h00;
         dir_up   <= 1'b1;
         tick_cnt <= '0;
         manual   <= 1'b0;
         led_reg  <= 8'h00;
         LED      <= 8'h00;
      end else begin
         mode     <= mode_next;
         pattern  <= pattern_next;
         dir_up   <= dir_up_next;
         tick_cnt <= tick_cnt_next;
         manual   <= manual_next;
         led_reg  <= led_reg_next;
         LED      <= manual ? led_reg : pattern;
      end
   end

   always_comb begin
      mode_next     = mode;
      pattern_next  = pattern;
      dir_up_next   = dir_up;
      tick_cnt_next = tick_cnt + 1'b1;
      manual_next   = manual;
      led_reg_next  = led_reg;

      if (tick) begin
         tick_cnt_next = '0;
         case (mode)
            MODE_COUNT:  pattern_next = pattern + 8'd1;
            MODE_ROTATE: pattern_next = {pattern[6:0], pattern[7]};
            MODE_BOUNCE: begin
               if (dir_up) begin
                  if (pattern[7]) begin
                     pattern_next = 8'h40;
                     dir_up_next  = 1'b0;
                  end else begin
                     pattern_next = pattern << 1;
                  end
               end else begin
                  if (pattern[0]) begin
                     pattern_next = 8'h02;
                     dir_up_next  = 1'b1;
                  end else begin
                     pattern_next = pattern >> 1;
                  end
               end
            end
            default:     pattern_next = ~pattern;
         endcase
      end

      if (press_hit) begin
         mode_next     = mode_t'(press_idx);
         pattern_next  = pattern_init(mode_t'(press_idx));
         dir_up_next   = 1'b1;
         tick_cnt_next = '0;
         manual_next   = 1'b0;
      end

      // A write overrides the manual-flag clear of a simultaneous press
      if (wr_en) begin
         led_reg_next = reg_wdata;
         manual_next  = 1'b1;
      end
   end

   assign reg_rdata = {manual, 1'b0, mode, ~deb_lvl};

endmodule

// File: tb/tb_led_driver.sv
// Randomized scoreboard bench for led_driver with a pattern-sequence reference model.
module tb_led_driver;

   localparam int TD = 4;
   localparam int DC = 3;

   logic       Clk = 1'b0;
   logic       rst_n;
   logic [3:0] Switch;
   logic       reg_cs;
   logic       reg_wr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic [7:0] LED;

   led_driver #(.TICK_DIV(TD), .DEB_CYCLES(DC)) dut (
      .Clk(Clk), .rst_n(rst_n), .Switch(Switch), .reg_cs(reg_cs),
      .reg_wr(reg_wr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .LED(LED)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0] led;
      logic [7:0] rdata;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
      end
   endtask

   // Pattern value after n ticks in a mode, straight from the sequence definitions
   function automatic logic [7:0] pat_of(input logic [1:0] md, input int n);
      int pos;
      case (md)
         2'd0: return 8'(n % 256);
         2'd1: return 8'(1 << (n % 8));
         2'd2: begin
            pos = n % 14;
            return (pos < 8) ? 8'(1 << pos) : 8'(1 << (14 - pos));
         end
         default: return (n % 2 == 0) ? 8'hFF : 8'h00;
      endcase
   endfunction

   logic [3:0] m_s1, m_s2, m_deb, m_press;
   logic [3:0] hist[$];
   logic [1:0] m_mode;
   logic       m_manual;
   logic [7:0] m_led_reg;
   int         m_c;

   logic [3:0] n_deb, n_press;
   logic [1:0] n_mode;
   logic       n_manual;
   logic [7:0] n_led_reg, n_led;
   int         n_c;
   bit         all_diff;
   exp_t       e_push;

   always @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = 4'hF; m_s2 = 4'hF; m_deb = 4'hF; m_press = 4'h0;
         hist.delete();
         m_mode = 2'd0; m_manual = 1'b0; m_led_reg = 8'h00; m_c = 0;
         sb.delete();
      end else begin
         n_led     = m_manual ? m_led_reg : pat_of(m_mode, m_c / TD);
         n_mode    = m_mode;
         n_c       = m_c + 1;
         n_manual  = m_manual;
         n_led_reg = m_led_reg;
         for (int k = 3; k >= 0; k--) begin
            if (m_press[k]) begin
               n_mode   = 2'(k);
               n_c      = 0;
               n_manual = 1'b0;
            end
         end
         if (reg_cs && reg_wr) begin
            n_led_reg = reg_wdata;
            n_manual  = 1'b1;
         end
         hist.push_back(m_s2);
         if (hist.size() > DC) void'(hist.pop_front());
         n_deb   = m_deb;
         n_press = 4'h0;
         for (int k = 0; k < 4; k++) begin
            all_diff = (hist.size() == DC);
            foreach (hist[j]) if (hist[j][k] == m_deb[k]) all_diff = 1'b0;
            if (all_diff) begin
               n_deb[k]   = ~m_deb[k];
               n_press[k] = ~n_deb[k];
            end
         end
         m_s2 = m_s1;
         m_s1 = Switch;
         m_deb = n_deb; m_press = n_press;
         m_mode = n_mode; m_manual = n_manual; m_led_reg = n_led_reg; m_c = n_c;
         e_push.led   = n_led;
         e_push.rdata = {n_manual, 1'b0, n_mode, ~n_deb};
         sb.push_back(e_push);
      end
   end

   exp_t e_pop;
   always @(posedge Clk) begin
      #1;
      if (rst_n) begin
         if (sb.size() == 0) begin
            chk("sb_empty", 8'h00, 8'h01);
         end else begin
            e_pop = sb.pop_front();
            chk("led", LED, e_pop.led);
            chk("rdata", reg_rdata, e_pop.rdata);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   initial begin
      Switch = 4'hF; reg_cs = 1'b0; reg_wr = 1'b0; reg_wdata = 8'h00; rst_n = 1'b0;
      cyc(2);
      chk("reset_led", LED, 8'h00);
      chk("reset_rdata", reg_rdata, 8'h00);
      rst_n = 1'b1;

      // Mode 0 count through a full 0xFF -> 0x00 wrap
      cyc(1100);

      // Mode 2 bounce
      Switch = 4'hB; cyc(6); Switch = 4'hF; cyc(80);

      // Bouncing button 1 must be rejected, then a steady press selects rotate
      for (int i = 0; i < 5; i++) begin
         Switch = 4'hD; cyc(2); Switch = 4'hF; cyc(2);
      end
      cyc(20);
      Switch = 4'hD; cyc(6); Switch = 4'hF; cyc(60);

      // Manual write, then button 3 returns to blink
      reg_cs = 1'b1; reg_wr = 1'b1; reg_wdata = 8'hA5; cyc(1);
      reg_cs = 1'b0; reg_wr = 1'b0; cyc(20);
      Switch = 4'h7; cyc(6); Switch = 4'hF; cyc(30);

      // Simultaneous presses 0 and 3
      Switch = 4'h6; cyc(6); Switch = 4'hF; cyc(30);

      // Write without select is ignored
      reg_cs = 1'b0; reg_wr = 1'b1; reg_wdata = 8'h5A; cyc(3); reg_wr = 1'b0; cyc(5);

      // Writes every cycle while a press lands: write wins on manual flag
      Switch = 4'hD; reg_cs = 1'b1; reg_wr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         reg_wdata = 8'($urandom); cyc(1);
      end
      reg_cs = 1'b0; reg_wr = 1'b0; Switch = 4'hF; cyc(30);

      // Randomized buttons and register traffic
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 7) == 0) Switch = 4'($urandom);
         reg_cs    = ($urandom_range(0, 59) == 0);
         reg_wr    = 1'($urandom);
         reg_wdata = 8'($urandom);
         cyc(1);
      end
      reg_cs = 1'b0; reg_wr = 1'b0; Switch = 4'hF; cyc(20);

      // Reset mid-debounce: no partial press survives
      Switch = 4'hE; cyc(3);
      #2 rst_n = 1'b0; Switch = 4'hF;
      #1 chk("rst_deb_led", LED, 8'h00);
      chk("rst_deb_rdata", reg_rdata, 8'h00);
      @(negedge Clk) rst_n = 1'b1;
      cyc(30);

      // Asynchronous reset mid-mode-2
      Switch = 4'hB; cyc(6); Switch = 4'hF; cyc(30);
      @(posedge Clk); #3 rst_n = 1'b0;
      #1 chk("rst_async_led", LED, 8'h00);
      chk("rst_async_rdata", reg_rdata, 8'h00);
      repeat (2) @(negedge Clk);
      rst_n = 1'b1;
      cyc(40);

      if (n_checks < 1000) chk("check_count", 8'h00, 8'h01);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
